// File: rtl/alu_wb_arbiter.sv
// Round-robin sharing of one writeback port among ALU result FIFOs.
// Define ALU_WB_ARB_PERF_EN to add the perf_conflict_cnt output.
`ifndef ALU_UNIT_NUM
`define ALU_UNIT_NUM 2
`endif

package alu_wb_pkg;
  typedef struct packed {
    logic        enable;
    logic [31:0] pc;
    logic [4:0]  rd;
    logic [31:0] value;
  } execute_wb_pack_t;
endpackage

module alu_wb_arbiter
  import alu_wb_pkg::*;
#(
  parameter int UNIT_NUM  = `ALU_UNIT_NUM,
  parameter int BUF_DEPTH = 2
) (
  input  logic                        clk,
  input  logic                        rst,
  input  execute_wb_pack_t            alu_data_in [UNIT_NUM],
  input  logic [UNIT_NUM-1:0]         alu_we,
  output logic [UNIT_NUM-1:0]         alu_full,
  input  logic                        flush,
  output execute_wb_pack_t            wb_data_out,
  output logic                        wb_data_out_valid,
  input  logic                        wb_ready,
  output logic [$clog2(UNIT_NUM)-1:0] grant_id
`ifdef ALU_WB_ARB_PERF_EN
  ,
  output logic [31:0]                 perf_conflict_cnt
`endif
);

  localparam int IW = $clog2(UNIT_NUM);
  localparam int PW = $clog2(BUF_DEPTH);
  localparam int CW = $clog2(BUF_DEPTH + 1);

  execute_wb_pack_t    mem [UNIT_NUM][BUF_DEPTH];
  logic [PW-1:0]       rd_ptr [UNIT_NUM];
  logic [PW-1:0]       wr_ptr [UNIT_NUM];
  logic [CW-1:0]       count [UNIT_NUM];
  logic [IW-1:0]       rr_ptr;

  logic [UNIT_NUM-1:0] nonempty;
  logic [UNIT_NUM-1:0] push;
  logic [UNIT_NUM-1:0] pop;
  logic                found;
  logic [IW-1:0]       grant;
  logic                pop_en;

  always_comb begin
    for (int i = 0; i < UNIT_NUM; i++) begin
      nonempty[i] = count[i] != '0;
      alu_full[i] = count[i] == CW'(BUF_DEPTH);
      push[i]     = alu_we[i] && !alu_full[i];
    end
  end

  // Scan from rr_ptr; with all FIFOs empty the grant rests on rr_ptr.
  always_comb begin
    int idx;
    idx   = 0;
    found = 1'b0;
    grant = rr_ptr;
    for (int k = 0; k < UNIT_NUM; k++) begin
      idx = int'(rr_ptr) + k;
      if (idx >= UNIT_NUM) idx = idx - UNIT_NUM;
      if (!found && nonempty[idx]) begin
        found = 1'b1;
        grant = IW'(idx);
      end
    end
  end

  assign wb_data_out_valid = found && !flush;
  assign grant_id          = grant;
  assign pop_en            = wb_data_out_valid && wb_ready;

  always_comb begin
    wb_data_out = '0;
    if (wb_data_out_valid) wb_data_out = mem[grant][rd_ptr[grant]];
  end

  always_comb begin
    for (int i = 0; i < UNIT_NUM; i++) begin
      pop[i] = pop_en && (grant == IW'(i));
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < UNIT_NUM; i++) begin
      if (push[i]) mem[i][wr_ptr[i]] <= alu_data_in[i];
    end
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      for (int i = 0; i < UNIT_NUM; i++) begin
        rd_ptr[i] <= '0;
        wr_ptr[i] <= '0;
        count[i]  <= '0;
      end
      rr_ptr <= '0;
    end else begin
      for (int i = 0; i < UNIT_NUM; i++) begin
        if (push[i]) wr_ptr[i] <= wr_ptr[i] + PW'(1);
        if (pop[i])  rd_ptr[i] <= rd_ptr[i] + PW'(1);
        case ({push[i], pop[i]})
          2'b10:   count[i] <= count[i] + CW'(1);
          2'b01:   count[i] <= count[i] - CW'(1);
          default: count[i] <= count[i];
        endcase
      end
      if (pop_en) begin
        rr_ptr <= (grant == IW'(UNIT_NUM - 1)) ? '0 : grant + IW'(1);
      end
    end
  end

`ifdef ALU_WB_ARB_PERF_EN
  logic [IW:0] busy_cnt;
  logic        conflict;

  always_comb begin
    busy_cnt = '0;
    for (int i = 0; i < UNIT_NUM; i++) begin
      busy_cnt = busy_cnt + (IW+1)'(nonempty[i]);
    end
    conflict = (busy_cnt >= (IW+1)'(2)) && !flush;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_conflict_cnt <= '0;
    end else if (conflict && perf_conflict_cnt != 32'hFFFF_FFFF) begin
      perf_conflict_cnt <= perf_conflict_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_alu_wb_arbiter.sv
// Bench for alu_wb_arbiter: queue-based model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_alu_wb_arbiter;
  import alu_wb_pkg::*;

  localparam int N = 2;
  localparam int D = 2;

  logic             clk = 1'b0;
  logic             rst;
  logic             flush;
  logic             wb_ready;
  logic [N-1:0]     alu_we;
  logic [N-1:0]     alu_full;
  execute_wb_pack_t alu_data_in [N];
  execute_wb_pack_t wb_data_out;
  logic             wb_data_out_valid;
  logic [0:0]       grant_id;
`ifdef ALU_WB_ARB_PERF_EN
  logic [31:0]      perf;
  logic [31:0]      p0;
`endif

  int checks   = 0;
  int failures = 0;
  bit chk_en   = 1'b0;

  always #5 clk = ~clk;

  alu_wb_arbiter #(.UNIT_NUM(N), .BUF_DEPTH(D)) dut (
    .clk              (clk),
    .rst              (rst),
    .alu_data_in      (alu_data_in),
    .alu_we           (alu_we),
    .alu_full         (alu_full),
    .flush            (flush),
    .wb_data_out      (wb_data_out),
    .wb_data_out_valid(wb_data_out_valid),
    .wb_ready         (wb_ready),
    .grant_id         (grant_id)
`ifdef ALU_WB_ARB_PERF_EN
    ,
    .perf_conflict_cnt(perf)
`endif
  );

  task automatic chk(input string nm, input logic [127:0] act,
                     input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  function automatic execute_wb_pack_t mk(input logic [31:0] pc);
    execute_wb_pack_t p;
    p.enable = 1'b1;
    p.pc     = pc;
    p.rd     = pc[6:2];
    p.value  = ~pc;
    return p;
  endfunction

  // Model: one queue per unit, a round-robin start index, a conflict counter.
  execute_wb_pack_t mq [N][$];
  int               m_rr = 0;
  logic [31:0]      m_perf = '0;

  function automatic int m_grant();
    for (int k = 0; k < N; k++) begin
      if (mq[(m_rr + k) % N].size() > 0) return (m_rr + k) % N;
    end
    return -1;
  endfunction

  always @(posedge clk) begin
    int g;
    int ne;
    bit [N-1:0] full;
    if (rst || flush) begin
      for (int i = 0; i < N; i++) mq[i].delete();
      m_rr = 0;
      if (rst) m_perf = '0;
    end else begin
      ne = 0;
      for (int i = 0; i < N; i++) ne += (mq[i].size() > 0) ? 1 : 0;
      if (ne >= 2 && m_perf != 32'hFFFF_FFFF) m_perf = m_perf + 1;
      for (int i = 0; i < N; i++) full[i] = mq[i].size() >= D;
      g = m_grant();
      if (g >= 0 && wb_ready) begin
        void'(mq[g].pop_front());
        m_rr = (g + 1) % N;
      end
      for (int i = 0; i < N; i++) begin
        if (alu_we[i] && !full[i]) mq[i].push_back(alu_data_in[i]);
      end
    end
  end

  always @(negedge clk) begin
    int g;
    bit ev;
    execute_wb_pack_t ed;
    if (chk_en) begin
      g  = m_grant();
      ev = (g >= 0) && !flush;
      ed = '0;
      if (ev) ed = mq[g][0];
      chk("m_valid", wb_data_out_valid, ev);
      chk("m_grant", grant_id, (g >= 0) ? g : m_rr);
      chk("m_data", wb_data_out, ed);
      for (int i = 0; i < N; i++) begin
        chk("m_full", alu_full[i], mq[i].size() >= D);
      end
`ifdef ALU_WB_ARB_PERF_EN
      chk("m_perf", perf, m_perf);
`endif
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; flush = 1'b0; wb_ready = 1'b0; alu_we = '0;
    alu_data_in[0] = '0; alu_data_in[1] = '0;
    cyc(); cyc();
    rst = 1'b0; chk_en = 1'b1;
    @(negedge clk);
    chk("rst_valid", wb_data_out_valid, 0);
    chk("rst_grant", grant_id, 0);
    chk("rst_full", alu_full, 0);
    chk("rst_data", wb_data_out, 0);

    // single pack through U0
    wb_ready = 1'b1; alu_we = 2'b01; alu_data_in[0] = mk(32'h100);
    cyc(); alu_we = '0;
    @(negedge clk);
    chk("t2_valid", wb_data_out_valid, 1);
    chk("t2_grant", grant_id, 0);
    chk("t2_pc", wb_data_out.pc, 32'h100);
    cyc();
    @(negedge clk);
    chk("t2_drain", wb_data_out_valid, 0);

    // flush while idle returns rr to unit 0
    cyc(); flush = 1'b1; cyc(); flush = 1'b0;

    // U0 and U1 together
    alu_we = 2'b11;
    alu_data_in[0] = mk(32'h200); alu_data_in[1] = mk(32'h300);
    cyc(); alu_we = '0;
    @(negedge clk);
    chk("t3_g0", grant_id, 0);
    chk("t3_pc0", wb_data_out.pc, 32'h200);
    cyc();
    @(negedge clk);
    chk("t3_g1", grant_id, 1);
    chk("t3_pc1", wb_data_out.pc, 32'h300);
    cyc();
    @(negedge clk);
    chk("t3_empty", wb_data_out_valid, 0);

    // after U0 wins, U1 goes first next round
    cyc(); alu_we = 2'b01; alu_data_in[0] = mk(32'h400);
    cyc(); alu_we = '0;
    @(negedge clk);
    chk("t3_pc400", wb_data_out.pc, 32'h400);
    cyc();
    alu_we = 2'b11;
    alu_data_in[0] = mk(32'h600); alu_data_in[1] = mk(32'h700);
    cyc(); alu_we = '0;
    @(negedge clk);
    chk("t3_rr_g", grant_id, 1);
    chk("t3_rr_pc", wb_data_out.pc, 32'h700);
    cyc();
    @(negedge clk);
    chk("t3_rr_g2", grant_id, 0);
    chk("t3_rr_pc2", wb_data_out.pc, 32'h600);
    cyc();
    @(negedge clk);
    chk("t3_rr_empty", wb_data_out_valid, 0);

    // stall: fill U0, drop third, hold output
    cyc(); wb_ready = 1'b0;
    alu_we = 2'b01; alu_data_in[0] = mk(32'hA00);
    cyc(); alu_data_in[0] = mk(32'hA04);
    cyc();
    @(negedge clk);
    chk("t4_full", alu_full[0], 1);
    alu_data_in[0] = mk(32'hA08);
    cyc(); alu_we = '0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("t4_hold_v", wb_data_out_valid, 1);
      chk("t4_hold_pc", wb_data_out.pc, 32'hA00);
      cyc();
    end
    wb_ready = 1'b1;
    @(negedge clk);
    chk("t4_d0", wb_data_out.pc, 32'hA00);
    cyc();
    @(negedge clk);
    chk("t4_d1", wb_data_out.pc, 32'hA04);
    cyc();
    @(negedge clk);
    chk("t4_done", wb_data_out_valid, 0);
    chk("t4_nfull", alu_full[0], 0);

    // flush with packs buffered
    wb_ready = 1'b0; alu_we = 2'b11;
    alu_data_in[0] = mk(32'hB00); alu_data_in[1] = mk(32'hB04);
    cyc(); alu_we = '0;
    cyc(); flush = 1'b1;
    @(negedge clk);
    chk("t5_fl_v", wb_data_out_valid, 0);
    cyc(); flush = 1'b0;
    @(negedge clk);
    chk("t5_post_v", wb_data_out_valid, 0);
    chk("t5_rr", grant_id, 0);
    wb_ready = 1'b1; alu_we = 2'b10; alu_data_in[1] = mk(32'hC00);
    cyc(); alu_we = '0;
    @(negedge clk);
    chk("t5_g", grant_id, 1);
    chk("t5_pc", wb_data_out.pc, 32'hC00);
    cyc();
    @(negedge clk);
    chk("t5_empty", wb_data_out_valid, 0);

    // reset mid-operation
    cyc(); wb_ready = 1'b0; alu_we = 2'b01; alu_data_in[0] = mk(32'hD00);
    cyc(); alu_we = '0; rst = 1'b1;
    cyc(); rst = 1'b0;
    @(negedge clk);
    chk("rst2_valid", wb_data_out_valid, 0);
    chk("rst2_full", alu_full, 0);

    // both units hold two packs, then drain
    wb_ready = 1'b0; alu_we = 2'b11;
    alu_data_in[0] = mk(32'hE00); alu_data_in[1] = mk(32'hE10);
    cyc();
    alu_data_in[0] = mk(32'hE04); alu_data_in[1] = mk(32'hE14);
    cyc(); alu_we = '0;
    @(negedge clk);
    chk("t6_full", alu_full, 2'b11);
`ifdef ALU_WB_ARB_PERF_EN
    p0 = perf;
`endif
    wb_ready = 1'b1;
    repeat (4) cyc();
    @(negedge clk);
    chk("t6_empty", wb_data_out_valid, 0);
`ifdef ALU_WB_ARB_PERF_EN
    chk("t6_perf", perf, p0 + 32'd3);
`endif
    flush = 1'b1;
    cyc(); flush = 1'b0;
    @(negedge clk);
`ifdef ALU_WB_ARB_PERF_EN
    chk("t6_perf_fl", perf, p0 + 32'd3);
`endif
    chk("t6_fl_v", wb_data_out_valid, 0);

    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
